// File: rtl/div_pkg.sv
// Shared definitions for the iterative divide sequencer.
//   XLEN        operand/result width (only 32 supported)
//   CNT_W       iteration counter width
//   state_e     sequencer states
//   DIV..REMU   M-extension func3 encodings handled here
package div_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] DIV  = 3'b100;
    localparam logic [2:0] DIVU = 3'b101;
    localparam logic [2:0] REM  = 3'b110;
    localparam logic [2:0] REMU = 3'b111;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
//   i_rem      partial remainder (always below the divisor)
//   i_bit      next dividend bit shifted in
//   i_divisor  divisor magnitude
//   o_rem      next partial remainder
//   o_qbit     quotient bit produced by this iteration
module div_step
    import div_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic            i_bit,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic            o_qbit
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    // Shifted remainder is below 2*divisor, so the top bit of the
    // XLEN+1 wide difference is a valid borrow flag.
    always_comb begin
        w_shift = {i_rem, i_bit};
        w_diff  = w_shift - {1'b0, i_divisor};
        o_qbit  = ~w_diff[XLEN];
        o_rem   = o_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU unit for the execute stage.
// Divide-by-zero and signed overflow finish in one cycle; all other ops
// run 32 restoring iterations on operand magnitudes.
// Optional feature: define DIV_CACHE_EN to remember the last iterated
// op so a repeat (e.g. DIV then REM of the same operands) finishes in
// one cycle.
//   clk, rst_n  clock, async active-low reset
//   start       op issue (accepted only in IDLE with func3[2]=1)
//   func3       op select, op_a/op_b dividend/divisor
//   flush       kill the op in flight
//   busy        combinational stall request
//   done        one-cycle result-valid pulse
//   result      quotient or remainder, held until the next done
module div_sequencer #(
    parameter int unsigned XLEN = div_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import div_pkg::state_e;
    import div_pkg::IDLE;
    import div_pkg::CALC;
    import div_pkg::DONE;
    import div_pkg::CNT_W;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_dvd;
    logic [XLEN-1:0]   r_dsr;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-2:0]   r_quo;
    logic [XLEN-1:0]   r_result;
    logic              r_is_rem;
    logic              r_neg_q;
    logic              r_neg_r;

    logic              w_signed;
    logic              w_zero;
    logic              w_ovf;
    logic              w_hit;
    logic [XLEN-1:0]   w_hit_res;
    logic [XLEN-1:0]   w_short_res;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [XLEN-1:0]   w_step_rem;
    logic              w_step_q;
    logic [XLEN-1:0]   w_q_fin;
    logic [XLEN-1:0]   w_q_out;
    logic [XLEN-1:0]   w_r_out;
    logic              w_busy;
    logic              w_slow_go;
    logic              w_short_go;
    logic              w_fin;

    // Operand classification for the op presented this cycle.
    always_comb begin
        w_signed = ~func3[0];
        w_zero   = (op_b == '0);
        w_ovf    = w_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        w_a_mag  = (w_signed && op_a[XLEN-1]) ? ('0 - op_a) : op_a;
        w_b_mag  = (w_signed && op_b[XLEN-1]) ? ('0 - op_b) : op_b;
        if (w_zero) begin
            w_short_res = func3[1] ? op_a : '1;
        end else if (w_ovf) begin
            // Overflow quotient equals the dividend (most negative value).
            w_short_res = func3[1] ? '0 : op_a;
        end else begin
            w_short_res = w_hit_res;
        end
    end

    div_step u_step (
        .i_rem     (r_rem),
        .i_bit     (r_dvd[r_cnt]),
        .i_divisor (r_dsr),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_q)
    );

    // Final iteration feeds the sign fix-up directly.
    always_comb begin
        w_q_fin = {r_quo, w_step_q};
        w_q_out = r_neg_q ? ('0 - w_q_fin) : w_q_fin;
        w_r_out = r_neg_r ? ('0 - w_step_rem) : w_step_rem;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control decode; flush overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_slow_go   = 1'b0;
        w_short_go  = 1'b0;
        w_fin       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && func3[2] && !flush) begin
                    if (w_zero || w_ovf || w_hit) begin
                        w_state_nxt = DONE;
                        w_short_go  = 1'b1;
                    end else begin
                        w_state_nxt = CALC;
                        w_busy      = 1'b1;
                        w_slow_go   = 1'b1;
                    end
                end
            end
            CALC: begin
                w_busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                    w_fin       = 1'b1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush) begin
            w_state_nxt = IDLE;
            w_fin       = 1'b0;
        end
    end

    // Operand capture, iteration and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dsr    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_slow_go) begin
                r_cnt    <= CNT_W'(XLEN - 1);
                r_dvd    <= w_a_mag;
                r_dsr    <= w_b_mag;
                r_rem    <= '0;
                r_quo    <= '0;
                r_is_rem <= func3[1];
                r_neg_q  <= w_signed && (op_a[XLEN-1] ^ op_b[XLEN-1]);
                r_neg_r  <= w_signed && op_a[XLEN-1];
            end else if (r_state == CALC) begin
                r_rem <= w_step_rem;
                r_quo <= {r_quo[XLEN-3:0], w_step_q};
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
            if (w_short_go) begin
                r_result <= w_short_res;
            end else if (w_fin) begin
                r_result <= r_is_rem ? w_r_out : w_q_out;
            end
        end
    end

`ifdef DIV_CACHE_EN
    logic              r_c_valid;
    logic              r_sgn;
    logic              r_c_sgn;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_c_a;
    logic [XLEN-1:0]   r_c_b;
    logic [XLEN-1:0]   r_c_q;
    logic [XLEN-1:0]   r_c_r;

    // Last completed iterated op; a flushed op never reaches w_fin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_valid <= 1'b0;
            r_sgn     <= 1'b0;
            r_c_sgn   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_c_a     <= '0;
            r_c_b     <= '0;
            r_c_q     <= '0;
            r_c_r     <= '0;
        end else begin
            if (w_slow_go) begin
                r_a   <= op_a;
                r_b   <= op_b;
                r_sgn <= w_signed;
            end
            if (w_fin) begin
                r_c_valid <= 1'b1;
                r_c_a     <= r_a;
                r_c_b     <= r_b;
                r_c_sgn   <= r_sgn;
                r_c_q     <= w_q_out;
                r_c_r     <= w_r_out;
            end
        end
    end

    assign w_hit     = r_c_valid && (op_a == r_c_a) && (op_b == r_c_b) && (w_signed == r_c_sgn);
    assign w_hit_res = func3[1] ? r_c_r : r_c_q;
`else
    assign w_hit     = 1'b0;
    assign w_hit_res = '0;
`endif

    assign busy   = w_busy;
    assign done   = (r_state == DONE);
    assign result = r_result;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed vectors, flush, reset,
// ignored starts and randomized ops against an arithmetic reference.
module tb_div_sequencer;
    import div_pkg::*;

`ifdef DIV_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] op_a  = '0;
    logic [31:0] op_b  = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: last expected result and last iterated op.
    logic [31:0] m_last = '0;
    bit          m_cv   = 1'b0;
    logic [31:0] m_ca   = '0;
    logic [31:0] m_cb   = '0;
    bit          m_cs   = 1'b0;

    div_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .func3  (func3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // RISC-V M-extension semantics in plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0] q;
        logic [31:0] r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (!f3[0]) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return f3[1] ? r : q;
    endfunction

    function automatic bit ref_short(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit ovf;
        bit hit;
        ovf = !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        hit = CACHE_EN && m_cv && a == m_ca && b == m_cb && (!f3[0]) == m_cs;
        return (b == 32'd0) || ovf || hit;
    endfunction

    // Issue one op (caller sits at a negedge) and check latency, busy and result.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit noise);
        logic [31:0] exp_r;
        bit          short_p;
        int          exp_lat;
        int          lat;
        int          busy_cnt;
        bit          got;
        exp_r   = ref_result(f3, a, b);
        short_p = ref_short(f3, a, b);
        exp_lat = short_p ? 1 : 33;
        start = 1'b1; func3 = f3; op_a = a; op_b = b;
        #1;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        @(posedge clk); @(negedge clk);
        got = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40 && !got; k++) begin
            busy_cnt += (busy === 1'b1) ? 1 : 0;
            if (done === 1'b1) begin
                got = 1'b1;
                lat = k;
                // A fast-path op offered in the DONE cycle must be ignored.
                start = noise; func3 = DIVU; op_a = $urandom; op_b = 32'd0;
            end else begin
                if (noise) begin
                    start = 1'($urandom_range(0, 1));
                    func3 = 3'($urandom);
                    op_a  = $urandom;
                    op_b  = 32'($urandom_range(0, 3));
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); @(negedge clk);
            end
        end
        n_total++;
        if (lat !== exp_lat) $display("FAIL latency f3=%b a=%h b=%h: got %0d expected %0d", f3, a, b, lat, exp_lat);
        else n_pass++;
        n_total++;
        if (result !== exp_r) $display("FAIL result f3=%b a=%h b=%h: got %h expected %h", f3, a, b, result, exp_r);
        else n_pass++;
        n_total++;
        if (busy_cnt !== (short_p ? 0 : 33)) $display("FAIL busy_cycles f3=%b a=%h b=%h: got %0d expected %0d", f3, a, b, busy_cnt, short_p ? 0 : 33);
        else n_pass++;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        #1;
        n_total++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL after_done: got done=%b busy=%b expected 0 0", done, busy);
        else n_pass++;
        m_last = exp_r;
        if (!short_p) begin
            m_cv = 1'b1; m_ca = a; m_cb = b; m_cs = !f3[0];
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0)
            $display("FAIL reset_state: got busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
        else n_pass++;
        m_cv = 1'b0; m_last = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [2:0]  t_f3[9]  = '{DIV, REM, DIV, REM, DIVU, DIVU, REMU, DIV, REM};
        logic [31:0] t_a[9]   = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] t_b[9]   = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_exp[9] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 9; i++) begin
            do_op(t_f3[i], t_a[i], t_b[i], 1'b0);
            n_total++;
            if (result !== t_exp[i]) $display("FAIL directed_%0d: got %h expected %h", i, result, t_exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_ignore();
        int n_done;
        // func3[2]=0 is not a divide op.
        start = 1'b1; func3 = 3'b000; op_a = 32'd100; op_b = 32'd7;
        #1;
        n_total++;
        if (busy !== 1'b0) $display("FAIL ignore_mul_busy: got %b expected 0", busy);
        else n_pass++;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        // flush beats a simultaneous start.
        start = 1'b1; flush = 1'b1; func3 = DIV; op_a = 32'd1000; op_b = 32'd3;
        #1;
        n_total++;
        if (busy !== 1'b0) $display("FAIL flush_start_busy: got %b expected 0", busy);
        else n_pass++;
        @(posedge clk); @(negedge clk);
        start = 1'b0; flush = 1'b0;
        n_done = 0;
        for (int k = 0; k < 4; k++) begin
            n_done += (done === 1'b1 || busy === 1'b1) ? 1 : 0;
            @(posedge clk); @(negedge clk);
        end
        n_total++;
        if (n_done !== 0) $display("FAIL ignore_activity: got %0d active cycles expected 0", n_done);
        else n_pass++;
        n_total++;
        if (result !== m_last) $display("FAIL ignore_result: got %h expected %h", result, m_last);
        else n_pass++;
    endtask

    // Start DIV a/b and flush it during CALC cycle 10; ends at negedge+1 after the flush edge.
    task automatic flush_op(input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; func3 = DIV; op_a = a; op_b = b;
        #1;
        n_total++;
        if (busy !== 1'b1) $display("FAIL flush_accept_busy: got %b expected 1", busy);
        else n_pass++;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (9) begin @(posedge clk); @(negedge clk); end
        flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        #1;
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL flush_idle: got busy=%b done=%b expected 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_flush();
        int n_done;
        do_op(DIV, 32'd100, 32'd7, 1'b0);
        flush_op(32'd200, 32'd7);
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            n_done += (done === 1'b1) ? 1 : 0;
            @(posedge clk); @(negedge clk);
        end
        n_total++;
        if (n_done !== 0) $display("FAIL flush_no_done: got %0d pulses expected 0", n_done);
        else n_pass++;
        n_total++;
        if (result !== 32'd14) $display("FAIL flush_result_hold: got %h expected %h", result, 32'd14);
        else n_pass++;
        // Restart right after a flush; the flushed op must not disturb the cache.
        flush_op(32'd300, 32'd7);
        do_op(REM, 32'd100, 32'd7, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        a = 32'd1;
        b = 32'd1;
        for (int i = 0; i < 50; i++) begin
            f3 = {1'b1, 2'($urandom)};
            if ($urandom_range(0, 3) != 0) begin
                a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
                case ($urandom_range(0, 4))
                    0:       b = 32'd0;
                    1:       b = 32'($urandom_range(1, 15));
                    2:       b = 32'hFFFF_FFFF;
                    3:       b = $urandom >> $urandom_range(0, 31);
                    default: b = $urandom;
                endcase
            end
            do_op(f3, a, b, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        int n_done;
        start = 1'b1; func3 = DIV; op_a = 32'd1000; op_b = 32'd3;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (5) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        #1;
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0)
            $display("FAIL reset_mid: got busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
        else n_pass++;
        m_cv = 1'b0; m_last = '0;
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            n_done += (done === 1'b1) ? 1 : 0;
            @(posedge clk); @(negedge clk);
        end
        n_total++;
        if (n_done !== 0) $display("FAIL reset_mid_no_done: got %0d pulses expected 0", n_done);
        else n_pass++;
        do_op(DIV, 32'd100, 32'd7, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore();
        test_flush();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
